sample_info_fetcher: RTL and testbench



---
 rtl/sampler_dma_pkg.sv | 23 ++
 rtl/sample_info_fetcher.sv | 157 +++++++++++++++
 tb/tb_sample_info_fetcher.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sampler_dma_pkg.sv
// Shared types and constants for the sampler DMA path: fetch FSM states and the
// packed layout of one sample-info BRAM word.
package sampler_dma_pkg;

    localparam int VOICE_ID_W     = 6;
    localparam int DMA_REQ_LEN    = 64;
    localparam int BYTES_PER_BEAT = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        PRESENT,
        WRITEBACK
    } fetch_state_t;

    // One BRAM word: upper half is remaining beats, lower half is DDR byte address.
    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] addr;
    } sample_info_t;

endpackage

// File: rtl/sample_info_fetcher.sv
// Walks the per-voice sample-info BRAM, presents each slot to the DMA requester and
// writes back the advanced address / decremented length after each issued request.
module sample_info_fetcher #(
    parameter int NUM_VOICES      = 64,
    parameter int REQ_LEN         = sampler_dma_pkg::DMA_REQ_LEN,
    parameter int BYTES_PER_BEAT  = sampler_dma_pkg::BYTES_PER_BEAT,
    parameter int BRAM_RD_LATENCY = 1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic                                stop,
    output logic [31:0]                         sample_addr,
    output logic [sampler_dma_pkg::VOICE_ID_W-1:0] sample_id,
    output logic                                sample_valid,
    output logic                                sample_overflow,
    output logic                                sample_last,
    input  logic                                load_next_sample,
    input  logic                                all_samples_invalid,
    output logic [sampler_dma_pkg::VOICE_ID_W-1:0] bram_addr,
    output logic                                bram_rd_en,
    input  logic [63:0]                         bram_rd_data,
    output logic                                bram_wr_en,
    output logic [63:0]                         bram_wr_data
);
    import sampler_dma_pkg::*;

    localparam logic [31:0]           ADDR_STEP = 32'(REQ_LEN * BYTES_PER_BEAT);
    localparam logic [31:0]           REQ_BEATS = 32'(REQ_LEN);
    localparam logic [VOICE_ID_W-1:0] LAST_ID   = VOICE_ID_W'(NUM_VOICES - 1);
    localparam logic [1:0]            WAIT_LAST = 2'(BRAM_RD_LATENCY - 1);

    fetch_state_t          state;
    logic [VOICE_ID_W-1:0] index;
    logic [VOICE_ID_W-1:0] index_next;
    logic [31:0]           addr_q;
    logic [31:0]           rem_q;
    logic [1:0]            wait_cnt;
    sample_info_t          rd_info;
    sample_info_t          wb_info;

    // Remaining length saturates at zero; the address simply wraps at 2^32.
    always_comb begin
        rd_info      = bram_rd_data;
        wb_info.addr = addr_q + ADDR_STEP;
        wb_info.rem  = (rem_q <= REQ_BEATS) ? '0 : rem_q - REQ_BEATS;
        index_next   = (index == LAST_ID) ? '0 : index + 1'b1;
    end

    // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            index           <= '0;
            addr_q          <= '0;
            rem_q           <= '0;
            wait_cnt        <= '0;
            sample_addr     <= '0;
            sample_id       <= '0;
            sample_valid    <= 1'b0;
            sample_overflow <= 1'b0;
            sample_last     <= 1'b0;
            bram_addr       <= '0;
            bram_rd_en      <= 1'b0;
            bram_wr_en      <= 1'b0;
            bram_wr_data    <= '0;
        end else begin
            // NOTE: non-blocking assignments everywhere in clocked logic so every register sees pre-edge values.
            bram_rd_en   <= 1'b0;
            bram_wr_en   <= 1'b0;
            sample_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    index <= '0;
                    if (start && !stop) begin
                        state      <= READ;
                        bram_rd_en <= 1'b1;
                        bram_addr  <= '0;
                    end
                end

                READ: begin
                    if (stop) begin
                        state <= IDLE;
                        index <= '0;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end

                WAIT: begin
                    if (stop) begin
                        state <= IDLE;
                        index <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        addr_q          <= rd_info.addr;
                        rem_q           <= rd_info.rem;
                        state           <= PRESENT;
                        sample_valid    <= 1'b1;
                        sample_addr     <= rd_info.addr;
                        sample_id       <= index;
                        sample_overflow <= (rd_info.rem == '0);
                        sample_last     <= (index == LAST_ID);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                PRESENT: begin
                    if (stop) begin
                        state <= IDLE;
                        index <= '0;
                    end else if (all_samples_invalid) begin
                        // Re-present entry 0 so the requester restarts cleanly.
                        index      <= '0;
                        state      <= READ;
                        bram_rd_en <= 1'b1;
                        bram_addr  <= '0;
                    end else if (load_next_sample && !sample_overflow) begin
                        state        <= WRITEBACK;
                        bram_wr_en   <= 1'b1;
                        bram_addr    <= index;
                        bram_wr_data <= wb_info;
                    end else if (load_next_sample) begin
                        index      <= index_next;
                        state      <= READ;
                        bram_rd_en <= 1'b1;
                        bram_addr  <= index_next;
                    end else begin
                        sample_valid <= 1'b1;
                    end
                end

                WRITEBACK: begin
                    // The write strobe is already on the bus this cycle, so stop cannot cancel it.
                    if (stop) begin
                        state <= IDLE;
                        index <= '0;
                    end else begin
                        index      <= index_next;
                        state      <= READ;
                        bram_rd_en <= 1'b1;
                        bram_addr  <= index_next;
                    end
                end

                default: begin
                    state <= IDLE;
                    index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_info_fetcher.sv
// Directed bench for sample_info_fetcher: a 1-cycle-latency instance covers the pass
// behaviour, a 2-cycle-latency instance covers fetch timing and address wrap.
module tb_sample_info_fetcher;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        start1 = 0, stop1 = 0, load1 = 0, inv1 = 0;
    logic [31:0] addr1;
    logic [5:0]  id1, baddr1;
    logic        valid1, ovf1, last1, rden1, wren1;
    logic [63:0] rdata1, wdata1;

    logic        start2 = 0, stop2 = 0, load2 = 0, inv2 = 0;
    logic [31:0] addr2;
    logic [5:0]  id2, baddr2;
    logic        valid2, ovf2, last2, rden2, wren2;
    logic [63:0] rdata2, wdata2, rd2_s1;

    sample_info_fetcher #(.BRAM_RD_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .stop(stop1),
        .sample_addr(addr1), .sample_id(id1), .sample_valid(valid1),
        .sample_overflow(ovf1), .sample_last(last1),
        .load_next_sample(load1), .all_samples_invalid(inv1),
        .bram_addr(baddr1), .bram_rd_en(rden1), .bram_rd_data(rdata1),
        .bram_wr_en(wren1), .bram_wr_data(wdata1)
    );

    sample_info_fetcher #(.BRAM_RD_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .stop(stop2),
        .sample_addr(addr2), .sample_id(id2), .sample_valid(valid2),
        .sample_overflow(ovf2), .sample_last(last2),
        .load_next_sample(load2), .all_samples_invalid(inv2),
        .bram_addr(baddr2), .bram_rd_en(rden2), .bram_rd_data(rdata2),
        .bram_wr_en(wren2), .bram_wr_data(wdata2)
    );

    // BRAM models plus a preload port driven by the stimulus tasks.
    logic [63:0] mem1 [64];
    logic [63:0] mem2 [64];
    logic        ld_all = 0, ld_one = 0, ld_sel = 0;
    logic [5:0]  ld_addr = 0;
    logic [63:0] ld_data = 0;
    int          wr_cnt1 = 0;
    int          wr_cnt2 = 0;

    always @(posedge clk) begin
        if (ld_all) begin
            for (int i = 0; i < 64; i++) begin
                if (ld_sel) mem2[i] <= ld_data;
                else        mem1[i] <= ld_data;
            end
        end
        if (ld_one) begin
            if (ld_sel) mem2[ld_addr] <= ld_data;
            else        mem1[ld_addr] <= ld_data;
        end
        if (wren1) begin
            mem1[baddr1] <= wdata1;
            wr_cnt1      <= wr_cnt1 + 1;
        end
        if (wren2) begin
            mem2[baddr2] <= wdata2;
            wr_cnt2      <= wr_cnt2 + 1;
        end
        if (rden1) rdata1 <= mem1[baddr1];
        if (rden2) rd2_s1 <= mem2[baddr2];
        rdata2 <= rd2_s1;
    end

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all(input logic sel, input logic [63:0] data);
        ld_sel = sel; ld_data = data; ld_all = 1;
        step();
        ld_all = 0;
    endtask

    task automatic load_slot(input logic sel, input logic [5:0] a, input logic [63:0] data);
        ld_sel = sel; ld_addr = a; ld_data = data; ld_one = 1;
        step();
        ld_one = 0;
    endtask

    task automatic wait_valid1(input string name);
        int n = 0;
        while (valid1 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (valid1 !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: sample_valid=%0b required 1", name, valid1);
        end
    endtask

    task automatic pulse_load1();
        load1 = 1;
        step();
        load1 = 0;
    endtask

    task automatic abort1();
        start1 = 0; stop1 = 1;
        step();
        stop1 = 0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 0;
        step();
        step();
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b need 0", valid1); end
        checks++; if (addr1 !== 32'h0) begin errors++; $display("FAIL reset_addr got %h need 0", addr1); end
        checks++; if (id1 !== 6'd0) begin errors++; $display("FAIL reset_id got %0d need 0", id1); end
        checks++; if ({ovf1, last1, rden1, wren1} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b need 0000", {ovf1, last1, rden1, wren1}); end
        checks++; if (wdata1 !== 64'h0 || baddr1 !== 6'd0) begin errors++; $display("FAIL reset_bram got data %h addr %0d need 0", wdata1, baddr1); end
        checks++; if (valid2 !== 1'b0 || rden2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 got valid %0b rd_en %0b need 0", valid2, rden2); end
        reset_n = 1;
        step();
        checks++; if (rden1 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL idle_no_start got rd_en %0b valid %0b need 0", rden1, valid1); end
    endtask

    task automatic test_fetch_writeback();
        int w0;
        fill_all(0, 64'h0);
        load_slot(0, 6'd0, {32'd200, 32'h1000_0000});
        load_slot(0, 6'd1, {32'd0, 32'h2000_0000});
        start1 = 1;
        step();
        start1 = 0;
        checks++; if (rden1 !== 1'b1 || baddr1 !== 6'd0) begin errors++; $display("FAIL read_cycle got rd_en %0b addr %0d need 1/0", rden1, baddr1); end
        step();
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL wait_cycle_valid got %0b need 0", valid1); end
        step();
        checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL latency1_valid got %0b need 1", valid1); end
        checks++; if (addr1 !== 32'h1000_0000) begin errors++; $display("FAIL slot0_addr got %h need 10000000", addr1); end
        checks++; if (id1 !== 6'd0 || ovf1 !== 1'b0 || last1 !== 1'b0) begin errors++; $display("FAIL slot0_flags got id %0d ovf %0b last %0b need 0/0/0", id1, ovf1, last1); end
        w0 = wr_cnt1;
        pulse_load1();
        checks++; if (wren1 !== 1'b1 || rden1 !== 1'b0 || baddr1 !== 6'd0) begin errors++; $display("FAIL wb_strobe got wr %0b rd %0b addr %0d need 1/0/0", wren1, rden1, baddr1); end
        checks++; if (wdata1 !== {32'd136, 32'h1000_0100}) begin errors++; $display("FAIL wb_data got %h need %h", wdata1, {32'd136, 32'h1000_0100}); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL wb_valid got %0b need 0", valid1); end
        step();
        checks++; if (rden1 !== 1'b1 || baddr1 !== 6'd1 || wren1 !== 1'b0) begin errors++; $display("FAIL next_read got rd %0b addr %0d wr %0b need 1/1/0", rden1, baddr1, wren1); end
        wait_valid1("slot1");
        checks++; if (id1 !== 6'd1 || ovf1 !== 1'b1 || addr1 !== 32'h2000_0000) begin errors++; $display("FAIL slot1 got id %0d ovf %0b addr %h need 1/1/20000000", id1, ovf1, addr1); end
        checks++; if (wr_cnt1 !== w0 + 1) begin errors++; $display("FAIL wb_count got %0d need %0d", wr_cnt1, w0 + 1); end
        abort1();
    endtask

    task automatic test_short_tail();
        int w0;
        fill_all(0, 64'h0);
        load_slot(0, 6'd0, {32'd40, 32'h3000_0000});
        start1 = 1;
        wait_valid1("tail_slot0");
        start1 = 0;
        pulse_load1();
        checks++; if (wren1 !== 1'b1 || wdata1 !== {32'd0, 32'h3000_0100}) begin errors++; $display("FAIL tail_wb got wr %0b data %h need 1/%h", wren1, wdata1, {32'd0, 32'h3000_0100}); end
        w0 = wr_cnt1 + 1;
        for (int i = 1; i < 64; i++) begin
            wait_valid1("tail_pass");
            checks++; if (id1 !== 6'(i)) begin errors++; $display("FAIL tail_id got %0d need %0d", id1, i); end
            pulse_load1();
            checks++; if (wren1 !== 1'b0) begin errors++; $display("FAIL tail_skip_write slot %0d got wr %0b need 0", i, wren1); end
        end
        wait_valid1("tail_wrap");
        checks++; if (id1 !== 6'd0 || ovf1 !== 1'b1 || addr1 !== 32'h3000_0100) begin errors++; $display("FAIL tail_second_pass got id %0d ovf %0b addr %h need 0/1/30000100", id1, ovf1, addr1); end
        pulse_load1();
        checks++; if (wren1 !== 1'b0) begin errors++; $display("FAIL tail_finished_write got %0b need 0", wren1); end
        step();
        checks++; if (wr_cnt1 !== w0) begin errors++; $display("FAIL tail_write_count got %0d need %0d", wr_cnt1, w0); end
        abort1();
    endtask

    task automatic test_last_slot();
        int w0;
        fill_all(0, 64'h0);
        load_slot(0, 6'd63, {32'd64, 32'h4000_0000});
        w0 = wr_cnt1;
        start1 = 1;
        for (int i = 0; i < 63; i++) begin
            wait_valid1("last_pass");
            start1 = 0;
            pulse_load1();
        end
        wait_valid1("last_slot63");
        checks++; if (id1 !== 6'd63 || last1 !== 1'b1 || ovf1 !== 1'b0) begin errors++; $display("FAIL slot63 got id %0d last %0b ovf %0b need 63/1/0", id1, last1, ovf1); end
        checks++; if (wr_cnt1 !== w0) begin errors++; $display("FAIL skip_writes got %0d need %0d", wr_cnt1, w0); end
        pulse_load1();
        checks++; if (wren1 !== 1'b1 || baddr1 !== 6'd63 || wdata1 !== {32'd0, 32'h4000_0100}) begin errors++; $display("FAIL slot63_wb got wr %0b addr %0d data %h", wren1, baddr1, wdata1); end
        step();
        checks++; if (rden1 !== 1'b1 || baddr1 !== 6'd0) begin errors++; $display("FAIL wrap_read got rd %0b addr %0d need 1/0", rden1, baddr1); end
        wait_valid1("last_wrap");
        checks++; if (id1 !== 6'd0 || last1 !== 1'b0) begin errors++; $display("FAIL wrap_id got id %0d last %0b need 0/0", id1, last1); end
        abort1();
    endtask

    task automatic test_all_invalid();
        fill_all(0, 64'h0);
        load_slot(0, 6'd63, {32'd64, 32'h5000_0000});
        start1 = 1;
        for (int i = 0; i < 63; i++) begin
            wait_valid1("inv_pass");
            start1 = 0;
            pulse_load1();
        end
        wait_valid1("inv_slot63");
        checks++; if (last1 !== 1'b1) begin errors++; $display("FAIL inv_last got %0b need 1", last1); end
        inv1 = 1; load1 = 1;
        step();
        inv1 = 0; load1 = 0;
        checks++; if (wren1 !== 1'b0 || rden1 !== 1'b1 || baddr1 !== 6'd0) begin errors++; $display("FAIL inv_priority got wr %0b rd %0b addr %0d need 0/1/0", wren1, rden1, baddr1); end
        wait_valid1("inv_restart");
        checks++; if (id1 !== 6'd0 || valid1 !== 1'b1) begin errors++; $display("FAIL inv_represent got id %0d valid %0b need 0/1", id1, valid1); end
        abort1();
    endtask

    task automatic test_stop();
        int w0;
        fill_all(0, 64'h0);
        load_slot(0, 6'd0, {32'd200, 32'h6000_0000});
        w0 = wr_cnt1;
        start1 = 1;
        step();
        step();
        stop1 = 1;
        step();
        checks++; if ({valid1, rden1, wren1} !== 3'b0) begin errors++; $display("FAIL stop_in_wait got v/rd/wr %b need 000", {valid1, rden1, wren1}); end
        step();
        checks++; if (rden1 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL stop_beats_start got rd %0b valid %0b need 0", rden1, valid1); end
        stop1 = 0;
        wait_valid1("stop_refetch");
        start1 = 0;
        stop1 = 1; load1 = 1;
        step();
        stop1 = 0; load1 = 0;
        checks++; if (wren1 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL stop_with_load got wr %0b valid %0b need 0", wren1, valid1); end
        step();
        checks++; if (wr_cnt1 !== w0 || valid1 !== 1'b0) begin errors++; $display("FAIL stop_no_write got count %0d valid %0b need %0d/0", wr_cnt1, valid1, w0); end
        start1 = 1;
        wait_valid1("stop_wb_fetch");
        start1 = 0;
        pulse_load1();
        checks++; if (wren1 !== 1'b1) begin errors++; $display("FAIL stop_wb_strobe got %0b need 1", wren1); end
        stop1 = 1;
        step();
        stop1 = 0;
        checks++; if ({valid1, rden1, wren1} !== 3'b0) begin errors++; $display("FAIL stop_in_wb got v/rd/wr %b need 000", {valid1, rden1, wren1}); end
        step();
        checks++; if (wr_cnt1 !== w0 + 1 || valid1 !== 1'b0) begin errors++; $display("FAIL stop_wb_count got %0d valid %0b need %0d/0", wr_cnt1, valid1, w0 + 1); end
    endtask

    task automatic test_latency2();
        fill_all(1, 64'h0);
        load_slot(1, 6'd0, {32'd128, 32'hFFFF_FF80});
        start2 = 1;
        step();
        start2 = 0;
        step();
        step();
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL lat2_cycle3 got %0b need 0", valid2); end
        step();
        checks++; if (valid2 !== 1'b1 || addr2 !== 32'hFFFF_FF80) begin errors++; $display("FAIL lat2_cycle4 got valid %0b addr %h need 1/ffffff80", valid2, addr2); end
        load2 = 1;
        step();
        load2 = 0;
        checks++; if (wren2 !== 1'b1 || wdata2 !== {32'd64, 32'h0000_0080}) begin errors++; $display("FAIL lat2_wrap_wb got wr %0b data %h need 1/%h", wren2, wdata2, {32'd64, 32'h0000_0080}); end
        stop2 = 1;
        step();
        stop2 = 0;
    endtask

    initial begin
        test_reset();
        test_fetch_writeback();
        test_short_tail();
        test_last_slot();
        test_all_invalid();
        test_stop();
        test_latency2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
